// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tags at issue, collects writeback results,
// retires one entry per cycle to the register file and flushes on a head mispredict.
module reorder_buffer #(
    parameter int ROB_WIDTH_BIT = 4,
    parameter int REG_ID_BIT    = 5
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     issue_en,
    input  logic [REG_ID_BIT-1:0]    issue_rd,
    input  logic                     issue_is_branch,
    input  logic                     issue_pred_taken,
    input  logic [31:0]              issue_alt_pc,
    output logic                     full,
    output logic [ROB_WIDTH_BIT-1:0] tail_id,
    input  logic                     wb_en,
    input  logic [ROB_WIDTH_BIT-1:0] wb_id,
    input  logic [31:0]              wb_value,
    input  logic                     wb_taken,
    input  logic [ROB_WIDTH_BIT-1:0] query1_id,
    input  logic [ROB_WIDTH_BIT-1:0] query2_id,
    output logic                     query1_ready,
    output logic                     query2_ready,
    output logic [31:0]              query1_value,
    output logic [31:0]              query2_value,
    output logic                     commit_en,
    output logic [REG_ID_BIT-1:0]    commit_reg,
    output logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
    output logic [31:0]              commit_value,
    output logic                     flush,
    output logic [31:0]              flush_pc
);

    localparam int DEPTH = 2 ** ROB_WIDTH_BIT;
    localparam logic [ROB_WIDTH_BIT:0] DEPTH_CNT = (ROB_WIDTH_BIT + 1)'(DEPTH);

    logic [DEPTH-1:0]      valid_q, ready_q, is_branch_q, pred_taken_q, taken_q;
    logic [REG_ID_BIT-1:0] rd_q     [DEPTH];
    logic [31:0]           alt_pc_q [DEPTH];
    logic [31:0]           value_q  [DEPTH];

    logic [ROB_WIDTH_BIT-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_WIDTH_BIT:0]   count_q, count_d;

    logic                     commit_en_q, commit_en_d;
    logic [REG_ID_BIT-1:0]    commit_reg_q, commit_reg_d;
    logic [ROB_WIDTH_BIT-1:0] commit_rob_id_q, commit_rob_id_d;
    logic [31:0]              commit_value_q, commit_value_d;
    logic                     flush_q, flush_d;
    logic [31:0]              flush_pc_q, flush_pc_d;

    logic head_done, commit_fire, flush_fire, issue_fire, wb_fire;
    logic q1_bypass, q2_bypass;

    assign full    = (count_q == DEPTH_CNT);
    assign tail_id = tail_q;

    assign head_done   = valid_q[head_q] & ready_q[head_q];
    assign commit_fire = rdy_in & head_done;
    assign flush_fire  = commit_fire & is_branch_q[head_q]
                         & (taken_q[head_q] != pred_taken_q[head_q]);
    // A full buffer refuses issue even when the head retires this cycle.
    assign issue_fire  = rdy_in & issue_en & ~full & ~flush_fire;
    assign wb_fire     = rdy_in & wb_en & valid_q[wb_id] & ~flush_fire;

    assign q1_bypass    = wb_en & (wb_id == query1_id) & valid_q[query1_id];
    assign q2_bypass    = wb_en & (wb_id == query2_id) & valid_q[query2_id];
    assign query1_ready = (valid_q[query1_id] & ready_q[query1_id]) | q1_bypass;
    assign query2_ready = (valid_q[query2_id] & ready_q[query2_id]) | q2_bypass;
    assign query1_value = q1_bypass ? wb_value : (query1_ready ? value_q[query1_id] : 32'd0);
    assign query2_value = q2_bypass ? wb_value : (query2_ready ? value_q[query2_id] : 32'd0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_fire) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (issue_fire)  tail_d = tail_q + 1'b1;
            if (commit_fire) head_d = head_q + 1'b1;
            count_d = count_q + {{ROB_WIDTH_BIT{1'b0}}, issue_fire}
                              - {{ROB_WIDTH_BIT{1'b0}}, commit_fire};
        end
    end

    always_comb begin
        commit_en_d     = 1'b0;
        commit_reg_d    = commit_reg_q;
        commit_rob_id_d = commit_rob_id_q;
        commit_value_d  = commit_value_q;
        flush_d         = 1'b0;
        flush_pc_d      = flush_pc_q;
        if (commit_fire && !is_branch_q[head_q] && rd_q[head_q] != '0) begin
            commit_en_d     = 1'b1;
            commit_reg_d    = rd_q[head_q];
            commit_rob_id_d = head_q;
            commit_value_d  = value_q[head_q];
        end
        if (flush_fire) begin
            flush_d    = 1'b1;
            flush_pc_d = alt_pc_q[head_q];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            commit_en_q     <= 1'b0;
            commit_reg_q    <= '0;
            commit_rob_id_q <= '0;
            commit_value_q  <= '0;
            flush_q         <= 1'b0;
            flush_pc_q      <= '0;
        end else begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            commit_en_q     <= commit_en_d;
            commit_reg_q    <= commit_reg_d;
            commit_rob_id_q <= commit_rob_id_d;
            commit_value_q  <= commit_value_d;
            flush_q         <= flush_d;
            flush_pc_q      <= flush_pc_d;
        end
    end

    // Payload fields need no reset: an entry is only read while its valid bit is set.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= '0;
            ready_q <= '0;
        end else if (flush_fire) begin
            valid_q <= '0;
        end else begin
            if (commit_fire) valid_q[head_q] <= 1'b0;
            if (issue_fire) begin
                valid_q[tail_q]      <= 1'b1;
                ready_q[tail_q]      <= 1'b0;
                rd_q[tail_q]         <= issue_rd;
                is_branch_q[tail_q]  <= issue_is_branch;
                pred_taken_q[tail_q] <= issue_pred_taken;
                alt_pc_q[tail_q]     <= issue_alt_pc;
            end
            if (wb_fire) begin
                ready_q[wb_id] <= 1'b1;
                value_q[wb_id] <= wb_value;
                taken_q[wb_id] <= wb_taken;
            end
        end
    end

    assign commit_en     = commit_en_q;
    assign commit_reg    = commit_reg_q;
    assign commit_rob_id = commit_rob_id_q;
    assign commit_value  = commit_value_q;
    assign flush         = flush_q;
    assign flush_pc      = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: issue/writeback ordering, full/wrap,
// mispredict flush, bypass queries, pause and reset during commit.
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        issue_en, issue_is_branch, issue_pred_taken;
    logic [4:0]  issue_rd;
    logic [31:0] issue_alt_pc;
    logic        full;
    logic [3:0]  tail_id;
    logic        wb_en, wb_taken;
    logic [3:0]  wb_id;
    logic [31:0] wb_value;
    logic [3:0]  query1_id, query2_id;
    logic        query1_ready, query2_ready;
    logic [31:0] query1_value, query2_value;
    logic        commit_en;
    logic [4:0]  commit_reg;
    logic [3:0]  commit_rob_id;
    logic [31:0] commit_value;
    logic        flush;
    logic [31:0] flush_pc;

    int checks = 0;
    int failures = 0;

    reorder_buffer #(.ROB_WIDTH_BIT(4), .REG_ID_BIT(5)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_is_branch(issue_is_branch),
        .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
        .full(full), .tail_id(tail_id),
        .wb_en(wb_en), .wb_id(wb_id), .wb_value(wb_value), .wb_taken(wb_taken),
        .query1_id(query1_id), .query2_id(query2_id),
        .query1_ready(query1_ready), .query2_ready(query2_ready),
        .query1_value(query1_value), .query2_value(query2_value),
        .commit_en(commit_en), .commit_reg(commit_reg), .commit_rob_id(commit_rob_id),
        .commit_value(commit_value), .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        rdy_in = 1'b1; issue_en = 1'b0; issue_rd = '0; issue_is_branch = 1'b0;
        issue_pred_taken = 1'b0; issue_alt_pc = '0; wb_en = 1'b0; wb_id = '0;
        wb_value = '0; wb_taken = 1'b0; query1_id = '0; query2_id = '0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic br, input logic pt,
                            input logic [31:0] alt);
        issue_en = 1'b1; issue_rd = rd; issue_is_branch = br;
        issue_pred_taken = pt; issue_alt_pc = alt;
        tick();
        issue_en = 1'b0; issue_is_branch = 1'b0; issue_pred_taken = 1'b0;
    endtask

    task automatic do_wb(input logic [3:0] id, input logic [31:0] val, input logic tk);
        wb_en = 1'b1; wb_id = id; wb_value = val; wb_taken = tk;
        tick();
        wb_en = 1'b0; wb_taken = 1'b0;
    endtask

    task automatic chk_commit(input string tag, input logic en, input logic [4:0] rg,
                              input logic [3:0] id, input logic [31:0] val);
        chk({tag, "_en"}, 32'(commit_en), 32'(en));
        if (en) begin
            chk({tag, "_reg"}, 32'(commit_reg), 32'(rg));
            chk({tag, "_id"}, 32'(commit_rob_id), 32'(id));
            chk({tag, "_val"}, commit_value, val);
        end
    endtask

    initial begin
        idle_inputs();
        rst_in = 1'b1;
        tick();
        do_reset();
        chk("rst_full", 32'(full), 0);
        chk("rst_tail", 32'(tail_id), 0);
        chk("rst_commit_en", 32'(commit_en), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_flush_pc", flush_pc, 0);

        // Three issues, then out-of-order writeback
        for (int i = 0; i < 3; i++) begin
            chk("issue_tail", 32'(tail_id), i);
            do_issue(5'(i + 1), 1'b0, 1'b0, 32'd0);
        end
        chk("issue_tail3", 32'(tail_id), 3);
        chk("issue_full", 32'(full), 0);
        chk("issue_no_commit", 32'(commit_en), 0);

        wb_en = 1'b1; wb_id = 4'd1; wb_value = 32'h22; query1_id = 4'd1; query2_id = 4'd2;
        #1;
        chk("q_bypass_rdy", 32'(query1_ready), 1);
        chk("q_bypass_val", query1_value, 32'h22);
        chk("q_none_rdy", 32'(query2_ready), 0);
        chk("q_none_val", query2_value, 0);
        tick();
        wb_en = 1'b0;
        #1;
        chk("ooo_no_commit", 32'(commit_en), 0);
        chk("q_stored_rdy", 32'(query1_ready), 1);
        chk("q_stored_val", query1_value, 32'h22);

        do_wb(4'd0, 32'h11, 1'b0);
        chk("wb_lat_no_commit", 32'(commit_en), 0);
        tick();
        chk_commit("c0", 1'b1, 5'd1, 4'd0, 32'h11);
        tick();
        chk_commit("c1", 1'b1, 5'd2, 4'd1, 32'h22);
        tick();
        chk_commit("c2_wait", 1'b0, 5'd0, 4'd0, 32'h0);

        wb_en = 1'b1; wb_id = 4'd2; wb_value = 32'hABCD; query1_id = 4'd2;
        #1;
        chk("q2_bypass_rdy", 32'(query1_ready), 1);
        chk("q2_bypass_val", query1_value, 32'hABCD);
        tick();
        wb_en = 1'b0;
        tick();
        chk_commit("c2", 1'b1, 5'd3, 4'd2, 32'hABCD);

        // Fill to full, overflow attempt, commit while full, wrap
        do_reset();
        for (int i = 0; i < 16; i++) do_issue(5'(i + 1), 1'b0, 1'b0, 32'd0);
        chk("fill_full", 32'(full), 1);
        chk("fill_tail", 32'(tail_id), 0);
        do_issue(5'd20, 1'b0, 1'b0, 32'd0);
        chk("ovf_full", 32'(full), 1);
        chk("ovf_tail", 32'(tail_id), 0);
        do_wb(4'd0, 32'h55, 1'b0);
        do_issue(5'd21, 1'b0, 1'b0, 32'd0);
        chk("full_commit_full", 32'(full), 0);
        chk("full_commit_tail", 32'(tail_id), 0);
        chk_commit("full_commit", 1'b1, 5'd1, 4'd0, 32'h55);
        do_issue(5'd22, 1'b0, 1'b0, 32'd0);
        chk("wrap_tail", 32'(tail_id), 1);
        chk("wrap_full", 32'(full), 1);

        // Mispredict at head flushes younger, ready entries
        do_reset();
        do_issue(5'd7, 1'b1, 1'b0, 32'h1000);
        do_issue(5'd8, 1'b0, 1'b0, 32'd0);
        do_issue(5'd9, 1'b0, 1'b0, 32'd0);
        do_wb(4'd1, 32'h77, 1'b0);
        do_wb(4'd2, 32'h88, 1'b0);
        do_wb(4'd0, 32'h0, 1'b1);
        do_issue(5'd10, 1'b0, 1'b0, 32'd0);
        chk("flush_pulse", 32'(flush), 1);
        chk("flush_pc", flush_pc, 32'h1000);
        chk("flush_tail", 32'(tail_id), 0);
        chk("flush_no_commit", 32'(commit_en), 0);
        tick();
        chk("flush_one_cycle", 32'(flush), 0);
        chk("flush_young1", 32'(commit_en), 0);
        tick();
        chk("flush_young2", 32'(commit_en), 0);
        chk("flush_tail_hold", 32'(tail_id), 0);

        // Correctly predicted branch retires quietly
        do_issue(5'd11, 1'b1, 1'b1, 32'h2000);
        do_wb(4'd0, 32'h0, 1'b1);
        tick();
        chk("br_ok_flush", 32'(flush), 0);
        chk("br_ok_commit", 32'(commit_en), 0);
        chk("br_ok_tail", 32'(tail_id), 1);

        // Pause with a ready head
        do_reset();
        do_issue(5'd5, 1'b0, 1'b0, 32'd0);
        do_wb(4'd0, 32'h99, 1'b0);
        rdy_in = 1'b0; issue_en = 1'b1; issue_rd = 5'd6;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pause_commit", 32'(commit_en), 0);
            chk("pause_tail", 32'(tail_id), 1);
        end
        rdy_in = 1'b1; issue_en = 1'b0;
        tick();
        chk_commit("post_pause", 1'b1, 5'd5, 4'd0, 32'h99);

        // Reset on the commit edge
        do_issue(5'd6, 1'b0, 1'b0, 32'd0);
        do_wb(4'd1, 32'h44, 1'b0);
        do_reset();
        chk("rc_commit_en", 32'(commit_en), 0);
        chk("rc_commit_reg", 32'(commit_reg), 0);
        chk("rc_commit_id", 32'(commit_rob_id), 0);
        chk("rc_commit_val", commit_value, 0);
        chk("rc_tail", 32'(tail_id), 0);
        chk("rc_flush", 32'(flush), 0);
        tick();
        chk("rc_after_commit", 32'(commit_en), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
